seg_monitor: RTL and testbench

SEG_MONITOR -- requirements
Module: seg_monitor

---
 rtl/seg_monitor_if.sv | 23 ++
 rtl/seg_monitor.sv | 111 +++++++++++
 tb/tb_seg_monitor.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_monitor_if.sv
// Bus bundle for seg_monitor: sampled segment inputs, timer/control strobes and
// the decoded-digit status outputs.
interface seg_monitor_if;
  logic [6:0] seg;
  logic       timeout;
  logic       dir;
  logic       clr;
  logic [3:0] digit;
  logic       digit_strobe;
  logic       bad_pattern;
  logic       seq_err;
  logic [7:0] tick_count;

  modport master (
    output seg, timeout, dir, clr,
    input  digit, digit_strobe, bad_pattern, seq_err, tick_count
  );

  modport slave (
    input  seg, timeout, dir, clr,
    output digit, digit_strobe, bad_pattern, seq_err, tick_count
  );
endinterface

// File: rtl/seg_monitor.sv
// Debounces a sampled 7-segment bus, decodes stable patterns to digits and checks
// that accepted digits follow a mod-8 up/down count; also counts timer pulses.
module seg_monitor #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_monitor_if.slave  bus
);

  localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

  typedef enum logic {StWaitFirst, StTrack} state_e;

  state_e     r_state;
  logic [6:0] r_seg_prev;
  logic [7:0] r_run;
  logic [3:0] r_digit;
  logic       r_strobe;
  logic       r_bad;
  logic       r_seq_err;
  logic [7:0] r_tick;

  logic [7:0] w_run_next;
  logic       w_accept;
  logic       w_valid;
  logic [3:0] w_dec;
  logic [3:0] w_expected;

  always_comb begin
    w_valid = 1'b1;
    w_dec   = 4'd0;
    unique case (bus.seg)
      7'b1111110: w_dec = 4'd0;
      7'b0110000: w_dec = 4'd1;
      7'b1101101: w_dec = 4'd2;
      7'b1111001: w_dec = 4'd3;
      7'b0110011: w_dec = 4'd4;
      7'b1011011: w_dec = 4'd5;
      7'b1011111: w_dec = 4'd6;
      7'b1110000: w_dec = 4'd7;
      7'b1111111: w_dec = 4'd8;
      7'b1111011: w_dec = 4'd9;
      default:    w_valid = 1'b0;
    endcase
  end

  always_comb begin
    // Run length saturates at the threshold so acceptance fires once per run.
    if (bus.seg != r_seg_prev) begin
      w_run_next = 8'd1;
    end else if (r_run == StableCnt) begin
      w_run_next = r_run;
    end else begin
      w_run_next = r_run + 8'd1;
    end
    w_accept   = (w_run_next == StableCnt) && (r_run != StableCnt);
    // Low three bits wrap naturally, giving the mod-8 successor/predecessor.
    w_expected = bus.dir ? {1'b0, r_digit[2:0] + 3'd1} : {1'b0, r_digit[2:0] - 3'd1};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StWaitFirst;
      r_seg_prev <= 7'd0;
      r_run      <= 8'd0;
      r_digit    <= 4'd0;
      r_strobe   <= 1'b0;
      r_bad      <= 1'b0;
      r_seq_err  <= 1'b0;
      r_tick     <= 8'd0;
    end else begin
      r_seg_prev <= bus.seg;
      r_strobe   <= 1'b0;
      if (bus.clr) begin
        r_state   <= StWaitFirst;
        r_run     <= 8'd0;
        r_bad     <= 1'b0;
        r_seq_err <= 1'b0;
        r_tick    <= 8'd0;
      end else begin
        r_run <= w_run_next;
        if (bus.timeout && (r_tick != 8'hFF)) begin
          r_tick <= r_tick + 8'd1;
        end
        if (w_accept) begin
          if (!w_valid) begin
            r_bad <= 1'b1;
          end else if (w_dec != r_digit) begin
            r_digit  <= w_dec;
            r_strobe <= 1'b1;
            if (r_state == StTrack) begin
              if ((w_dec > 4'd7) || (w_dec != w_expected)) begin
                r_seq_err <= 1'b1;
              end
            end else begin
              r_state <= StTrack;
            end
          end
        end
      end
    end
  end

  assign bus.digit        = r_digit;
  assign bus.digit_strobe = r_strobe;
  assign bus.bad_pattern  = r_bad;
  assign bus.seq_err      = r_seq_err;
  assign bus.tick_count   = r_tick;

endmodule

// File: tb/tb_seg_monitor.sv
// Directed bench for seg_monitor with STABLE_CYCLES=4 and hand-computed expectations.
module tb_seg_monitor;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_strobe;
  logic [6:0] pat_tab [10];

  seg_monitor_if bus ();

  seg_monitor #(
    .STABLE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
    if (bus.digit_strobe === 1'b1) n_strobe++;
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    bus.seg = p;
    repeat (n) cycle();
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.seg = 7'd0; bus.timeout = 1'b0; bus.dir = 1'b1; bus.clr = 1'b0;
    cycle();
    n_checks++;
    if (bus.digit !== 4'd0) begin
      n_fail++; $display("FAIL reset_digit: got %0d expected 0", bus.digit);
    end
    n_checks++;
    if ({bus.digit_strobe, bus.bad_pattern, bus.seq_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000",
               {bus.digit_strobe, bus.bad_pattern, bus.seq_err});
    end
    n_checks++;
    if (bus.tick_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_tick: got %0d expected 0", bus.tick_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_filter();
    n_strobe = 0;
    hold(pat_tab[1], 3);
    n_checks++;
    if (bus.digit !== 4'd0 || n_strobe != 0) begin
      n_fail++;
      $display("FAIL filter_short_run: got digit %0d strobes %0d expected 0 0", bus.digit,
               n_strobe);
    end
    hold(pat_tab[2], 3);
    n_checks++;
    if (bus.digit !== 4'd0) begin
      n_fail++; $display("FAIL filter_early: got %0d expected 0", bus.digit);
    end
    cycle();
    n_checks++;
    if (bus.digit !== 4'd2 || bus.digit_strobe !== 1'b1) begin
      n_fail++;
      $display("FAIL filter_accept: got digit %0d strobe %b expected 2 1", bus.digit,
               bus.digit_strobe);
    end
    repeat (2) cycle();
    n_checks++;
    if (n_strobe != 1 || bus.seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL filter_once: got strobes %0d seq_err %b expected 1 0", n_strobe,
               bus.seq_err);
    end
  endtask

  task automatic test_sequence();
    int seq [4] = '{6, 7, 0, 1};
    pulse_clr();
    n_checks++;
    if (bus.digit !== 4'd2) begin
      n_fail++; $display("FAIL clr_digit_hold: got %0d expected 2", bus.digit);
    end
    bus.dir = 1'b1;
    n_strobe = 0;
    for (int i = 0; i < 4; i++) begin
      hold(pat_tab[seq[i]], 4);
      n_checks++;
      if (bus.digit !== 4'(seq[i])) begin
        n_fail++; $display("FAIL seq_up_digit: got %0d expected %0d", bus.digit, seq[i]);
      end
    end
    n_checks++;
    if (n_strobe != 4 || bus.seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_up: got strobes %0d seq_err %b expected 4 0", n_strobe, bus.seq_err);
    end
    bus.dir = 1'b0;
    hold(pat_tab[3], 4);
    n_checks++;
    if (bus.seq_err !== 1'b1 || bus.digit !== 4'd3) begin
      n_fail++;
      $display("FAIL seq_down_err: got seq_err %b digit %0d expected 1 3", bus.seq_err,
               bus.digit);
    end
    hold(pat_tab[2], 4);
    n_checks++;
    if (bus.seq_err !== 1'b1 || bus.digit !== 4'd2) begin
      n_fail++;
      $display("FAIL seq_sticky: got seq_err %b digit %0d expected 1 2", bus.seq_err,
               bus.digit);
    end
  endtask

  task automatic test_bad_pattern();
    pulse_clr();
    n_checks++;
    if (bus.seq_err !== 1'b0) begin
      n_fail++; $display("FAIL clr_seq_err: got %b expected 0", bus.seq_err);
    end
    bus.dir = 1'b1;
    hold(pat_tab[3], 4);
    n_strobe = 0;
    hold(7'b0000001, 4);
    n_checks++;
    if (bus.bad_pattern !== 1'b1 || bus.digit !== 4'd3 || n_strobe != 0) begin
      n_fail++;
      $display("FAIL bad_pattern: got bad %b digit %0d strobes %0d expected 1 3 0",
               bus.bad_pattern, bus.digit, n_strobe);
    end
    hold(pat_tab[4], 4);
    n_checks++;
    if (bus.digit !== 4'd4 || n_strobe != 1 || bus.seq_err !== 1'b0 || bus.bad_pattern !== 1'b1)
    begin
      n_fail++;
      $display("FAIL bad_then_valid: got digit %0d strobes %0d seq_err %b bad %b expected 4 1 0 1",
               bus.digit, n_strobe, bus.seq_err, bus.bad_pattern);
    end
  endtask

  task automatic test_equal_and_hold();
    n_strobe = 0;
    hold(pat_tab[5], 2);
    hold(pat_tab[4], 6);
    n_checks++;
    if (bus.digit !== 4'd4 || n_strobe != 0) begin
      n_fail++;
      $display("FAIL equal_value: got digit %0d strobes %0d expected 4 0", bus.digit, n_strobe);
    end
    hold(pat_tab[5], 20);
    n_checks++;
    if (bus.digit !== 4'd5 || n_strobe != 1 || bus.seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL long_hold: got digit %0d strobes %0d seq_err %b expected 5 1 0", bus.digit,
               n_strobe, bus.seq_err);
    end
  endtask

  task automatic test_timeout();
    bus.timeout = 1'b1;
    repeat (3) cycle();
    n_checks++;
    if (bus.tick_count !== 8'd3) begin
      n_fail++; $display("FAIL tick_count3: got %0d expected 3", bus.tick_count);
    end
    repeat (297) cycle();
    n_checks++;
    if (bus.tick_count !== 8'd255) begin
      n_fail++; $display("FAIL tick_saturate: got %0d expected 255", bus.tick_count);
    end
    pulse_clr();
    n_checks++;
    if (bus.tick_count !== 8'd0 || bus.bad_pattern !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_with_timeout: got tick %0d bad %b expected 0 0", bus.tick_count,
               bus.bad_pattern);
    end
    cycle();
    bus.timeout = 1'b0;
    cycle();
    n_checks++;
    if (bus.tick_count !== 8'd1) begin
      n_fail++; $display("FAIL tick_after_clr: got %0d expected 1", bus.tick_count);
    end
  endtask

  task automatic test_reset_midrun();
    bus.timeout = 1'b1;
    hold(pat_tab[7], 2);
    bus.timeout = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    n_checks++;
    if (bus.digit !== 4'd0 || bus.tick_count !== 8'd0 ||
        {bus.digit_strobe, bus.bad_pattern, bus.seq_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrun_reset: got digit %0d tick %0d flags %b expected 0 0 000", bus.digit,
               bus.tick_count, {bus.digit_strobe, bus.bad_pattern, bus.seq_err});
    end
    n_strobe = 0;
    repeat (3) cycle();
    n_checks++;
    if (bus.digit !== 4'd0 || n_strobe != 0) begin
      n_fail++;
      $display("FAIL midrun_early: got digit %0d strobes %0d expected 0 0", bus.digit, n_strobe);
    end
    cycle();
    n_checks++;
    if (bus.digit !== 4'd7 || bus.digit_strobe !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_accept: got digit %0d strobe %b expected 7 1", bus.digit,
               bus.digit_strobe);
    end
    cycle();
    n_checks++;
    if (bus.digit_strobe !== 1'b0 || n_strobe != 1) begin
      n_fail++;
      $display("FAIL midrun_pulse: got strobe %b count %0d expected 0 1", bus.digit_strobe,
               n_strobe);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_strobe = 0;
    pat_tab[0] = 7'b1111110; pat_tab[1] = 7'b0110000; pat_tab[2] = 7'b1101101;
    pat_tab[3] = 7'b1111001; pat_tab[4] = 7'b0110011; pat_tab[5] = 7'b1011011;
    pat_tab[6] = 7'b1011111; pat_tab[7] = 7'b1110000; pat_tab[8] = 7'b1111111;
    pat_tab[9] = 7'b1111011;
    test_reset();
    test_filter();
    test_sequence();
    test_bad_pattern();
    test_equal_and_hold();
    test_timeout();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
